fetch_queue: RTL
================

# fetch_queue

Parametrised fetch-to-decode decoupling stage. It replaces the single F/D pipeline register with a DEPTH-entry instruction queue feeding a registered decode-side output. Fetch can run ahead while decode stalls. Branch mispredictions from D or E flush the queue and load a redirect bubble whose pc is nextpc-4, which suppresses false mispredict detection.

## Interface
- XLEN, 32, pc/instruction width
- DEPTH, 4, queue entries; power of 2, ≥2
- RESET_PC, 32'h00008000, architectural start pc; reset bubble pc is RESET_PC-4

- CLK  in  1  clock
- NRST  in  1  reset, synchronous, active-low
- pcF  in  XLEN  pc of fetched instruction
- instF  in  XLEN  fetched instruction
- validF  in  1  pcF/instF valid this cycle
- readyF  out  1  queue can accept; =(count<DEPTH)
- stall  in  1  decode not consuming; output register holds
- fail_predictD  in  1  mispredict detected in D
- fail_predictE  in  1  mispredict detected in E
- nextpc  in  XLEN  redirect target
- pcD  out  XLEN  pc presented to decode
- instD  out  XLEN  instruction presented to decode; 0 = bubble
- validD  out  1  instD is a real instruction
- count  out  $clog2(DEPTH+1)  queue occupancy, excluding output register

## Operation
- Storage: circular buffer with rd/wr pointers of log2(DEPTH) bits that wrap naturally, plus a count register.
- Push: validF && readyF (and not flushing) writes {pcF,instF} at wr, then wr+1.
- Output register update happens when !stall, evaluated in priority order:
  1. fail = fail_predictD|fail_predictE → pcD=nextpc-4 (mod 2^XLEN), instD=0, validD=0. Queue cleared (rd=wr=0, count=0). Push this cycle discarded.
  2. count>0 → load head entry, rd+1, validD=1.
  3. count==0 && validF → bypass: load pcF/instF directly, validD=1. Nothing is written to the queue. Requires FQ_BYPASS_EN.
  4. Otherwise → bubble: instD=0, validD=0, pcD unchanged.
- stall=1: output register holds. fail is ignored entirely that cycle, and the queue is not flushed; decode reasserts fail after the stall releases. Pushes continue while readyF.
- Simultaneous pop and push: count is unchanged, and both pointers advance.
- readyF is computed from registered count only. A same-cycle pop does not free a slot (conservative).
- count never exceeds DEPTH. Pop from empty and push when full are impossible by construction.

## Timing
- Reset (NRST=0 at posedge): pcD=RESET_PC-4, instD=0, validD=0, rd=wr=count=0. readyF=1 the next cycle.
- Reset mid-operation discards all queued entries.
- Latency from fetch to decode:
  - Empty queue with bypass: 1 cycle.
  - Through the queue: 2 cycles minimum.
- Flush takes effect at the posedge where fail is seen with !stall. Fetch of nextpc may push from the following cycle.
- All outputs are registered except readyF, which is combinational from count.

## Configuration
- FQ_BYPASS_EN defined: the empty-queue bypass (rule 3) is present, giving 1-cycle latency, identical to the legacy register.
- Not defined: every instruction enters the queue. Rule 3 becomes a push, and the minimum latency is 2 cycles.

## Structure
- Package fq_pkg holds:
  - NOP_INST = 32'd0
  - pc_inst_t struct {pc, inst}
  - the default RESET_PC constant
- Sub-module fetch_queue_mem holds the storage array, pointers and count, with push/pop/clear ports. fetch_queue adds the output register and priority logic.

## Test plan
- Reset: NRST=0 then 1 → pcD=0x7ffc, instD=0, validD=0, count=0, readyF=1.
- Streaming with no stall, FQ_BYPASS_EN: push pc 0x8000, 0x8004, 0x8008 on consecutive cycles → each appears on pcD one cycle later, count stays 0.
- Fill: stall=1, push 5 instructions (DEPTH=4) → readyF=0 after 4, 5th held upstream. Release stall → entries emerge in order 0x8000..0x800c, readyF returns to 1.
- Flush: queue holding 3 entries, fail_predictE=1, nextpc=0x9000, stall=0 → pcD=0x8ffc, instD=0, validD=0, count=0, and the concurrent push is dropped.
- Stall beats fail: stall=1, fail_predictD=1 → pcD/instD unchanged, count unchanged. Next cycle, stall=0 with fail still asserted → flush occurs.
- Wrap: with DEPTH=4, run 10 push/pop pairs with pc incrementing by 4 → output order is preserved across pointer wrap, and count is never >4.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the fetch-to-decode queue.
package fq_pkg;

  localparam logic [31:0] NOP_INST         = 32'd0;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_8000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } pc_inst_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side handshake bundle: fetch unit is master, queue is slave.
interface fetch_queue_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] pcF;
  logic [XLEN-1:0] instF;
  logic            validF;
  logic            readyF;

  modport master (output pcF, output instF, output validF, input readyF);
  modport slave  (input pcF, input instF, input validF, output readyF);
endinterface

// File: rtl/fetch_queue_mem.sv
// Circular instruction buffer: storage, wrapping rd/wr pointers and occupancy count.
module fetch_queue_mem #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              NRST,
  input  logic              push,
  input  logic              pop,
  input  logic              clear,
  input  logic [2*XLEN-1:0] wdata,
  output logic [2*XLEN-1:0] rdata,
  output logic [CW-1:0]     count
);

  logic [2*XLEN-1:0] mem_q [DEPTH];
  logic [2*XLEN-1:0] mem_d [DEPTH];
  logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]     count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (clear) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = wdata;
        wr_d        = wr_q + PW'(1);
      end
      if (pop) rd_d = rd_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Storage has no reset; only the pointers and count define validity.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  assign rdata = mem_q[rd_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling queue with registered decode-side output.
// Define FQ_BYPASS_EN to forward fetch straight to decode when the queue is empty.
module fetch_queue
  import fq_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic                       CLK,
  input  logic                       NRST,
  fetch_queue_if.slave               fq,
  input  logic                       stall,
  input  logic                       fail_predictD,
  input  logic                       fail_predictE,
  input  logic [XLEN-1:0]            nextpc,
  output logic [XLEN-1:0]            pcD,
  output logic [XLEN-1:0]            instD,
  output logic                       validD,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0]   pc_q, pc_d, inst_q, inst_d;
  logic              valid_q, valid_d;
  logic              push, pop, clear, fail;
  logic [2*XLEN-1:0] head;

  fetch_queue_mem #(.XLEN(XLEN), .DEPTH(DEPTH)) u_mem (
    .CLK   (CLK),
    .NRST  (NRST),
    .push  (push),
    .pop   (pop),
    .clear (clear),
    .wdata ({fq.pcF, fq.instF}),
    .rdata (head),
    .count (count)
  );

  // Readiness looks only at registered occupancy; a same-cycle pop frees nothing.
  assign fq.readyF = (count < CW'(DEPTH));

  always_comb begin
    fail    = fail_predictD | fail_predictE;
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    pop     = 1'b0;
    clear   = 1'b0;
    push    = fq.validF & fq.readyF;
    if (!stall) begin
      if (fail) begin
        clear   = 1'b1;
        push    = 1'b0;
        pc_d    = nextpc - XLEN'(4);
        inst_d  = XLEN'(NOP_INST);
        valid_d = 1'b0;
      end else if (count != '0) begin
        pop            = 1'b1;
        {pc_d, inst_d} = head;
        valid_d        = 1'b1;
`ifdef FQ_BYPASS_EN
      end else if (fq.validF) begin
        push    = 1'b0;
        pc_d    = fq.pcF;
        inst_d  = fq.instF;
        valid_d = 1'b1;
`endif
      end else begin
        inst_d  = XLEN'(NOP_INST);
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      pc_q    <= RESET_PC - XLEN'(4);
      inst_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

  assign pcD    = pc_q;
  assign instD  = inst_q;
  assign validD = valid_q;

endmodule
